// File: rtl/aes_pnm_job_scheduler.sv
// aes_pnm_job_scheduler
// Job front-end for aes_pnm_controller. Host jobs are queued in a small FIFO.
// Each job is split into 4-row AES blocks, and one start pulse is issued per
// block. The round count is checked when the controller reports done, and one
// status response is returned per job. A watchdog guards each block.

module aes_pnm_job_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int ROW_W      = 4,
  parameter int CNT_W      = 8,
  parameter int N_ROUNDS   = 10,
  parameter int TIMEOUT    = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_enc_dec,
  input  logic [ROW_W-1:0]              cmd_base_row,
  input  logic [CNT_W-1:0]              cmd_nblocks,
  input  logic [3:0]                    cmd_id,
  output logic                          ctl_start,
  output logic                          ctl_enc_dec,
  output logic [ROW_W-1:0]              ctl_base_row,
  input  logic                          ctl_done,
  input  logic [3:0]                    ctl_round,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [3:0]                    rsp_id,
  output logic [1:0]                    rsp_status,
  output logic [CNT_W-1:0]              rsp_blocks,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  // state   | meaning
  // S_IDLE  | waiting for a queued job; pops and latches it
  // S_ISSUE | one-cycle start pulse for block k, watchdog cleared
  // S_WAIT  | waiting for controller done or watchdog expiry
  // S_RESP  | response held until the host accepts it

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int WD_W  = $clog2(TIMEOUT) + 1;

  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT - 1);
  localparam logic [3:0]       ROUND_OK  = 4'(N_ROUNDS);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_BAD_RND = 2'b10;
  localparam logic [1:0] ST_ZERO    = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic             enc_dec;
    logic [ROW_W-1:0] base_row;
    logic [CNT_W-1:0] nblocks;
    logic [3:0]       id;
  } job_t;

  state_t state, state_nxt;

  job_t             fifo_mem [FIFO_DEPTH];
  job_t             cmd_job;
  job_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic [LVL_W-1:0] level_nxt;
  logic             ready_q;
  logic             push;
  logic             pop;

  logic [3:0]       id_q;
  logic [ROW_W-1:0] base_q;
  logic [CNT_W-1:0] nblk_q;
  logic [CNT_W-1:0] k_q;
  logic [CNT_W-1:0] k_inc;
  logic [ROW_W-1:0] row_q;
  logic             enc_q;
  logic [WD_W-1:0]  wd_q;
  logic [3:0]       rsp_id_q;
  logic [1:0]       rsp_status_q;
  logic [CNT_W-1:0] rsp_blocks_q;

  logic             round_ok;
  logic             last_blk;
  logic             wd_expired;
  logic [CNT_W+1:0] row_step;
  logic [ROW_W-1:0] next_row;

  assign cmd_job = {cmd_enc_dec, cmd_base_row, cmd_nblocks, cmd_id};
  assign head    = fifo_mem[rd_ptr];

  // cmd_ready comes from a register so it never depends on this cycle's pop.
  assign push = cmd_valid & ready_q;

  assign round_ok   = (ctl_round == ROUND_OK);
  assign last_blk   = ({1'b0, k_q} + 1'b1) == {1'b0, nblk_q};
  assign wd_expired = (wd_q == WD_LIMIT);
  assign k_inc      = k_q + 1'b1;
  assign row_step   = {k_inc, 2'b00};
  assign next_row   = base_q + ROW_W'(row_step);

  assign cmd_ready    = ready_q;
  assign fifo_level   = level;
  assign ctl_enc_dec  = enc_q;
  assign ctl_base_row = row_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_status   = rsp_status_q;
  assign rsp_blocks   = rsp_blocks_q;

  // FIFO occupancy for the next cycle.
  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  // FIFO pointers, level and registered ready; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level   <= level_nxt;
      ready_q <= (level_nxt != LVL_FULL);
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= cmd_job;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic; controller done beats a same-cycle timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (level != '0)
          state_nxt = (head.nblocks == '0) ? S_RESP : S_ISSUE;
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (ctl_done)
          state_nxt = (!round_ok || last_blk) ? S_RESP : S_ISSUE;
        else if (wd_expired)
          state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    ctl_start = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        pop  = (level != '0);
      end
      S_ISSUE: ctl_start = 1'b1;
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Job context, block counter, watchdog and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q         <= '0;
      base_q       <= '0;
      nblk_q       <= '0;
      k_q          <= '0;
      row_q        <= '0;
      enc_q        <= 1'b0;
      wd_q         <= '0;
      rsp_id_q     <= '0;
      rsp_status_q <= '0;
      rsp_blocks_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            id_q   <= head.id;
            base_q <= head.base_row;
            nblk_q <= head.nblocks;
            enc_q  <= head.enc_dec;
            row_q  <= head.base_row;
            k_q    <= '0;
            if (head.nblocks == '0) begin
              rsp_id_q     <= head.id;
              rsp_status_q <= ST_ZERO;
              rsp_blocks_q <= '0;
            end
          end
        end
        S_ISSUE: wd_q <= '0;
        S_WAIT: begin
          wd_q <= wd_q + 1'b1;
          if (ctl_done) begin
            if (!round_ok) begin
              rsp_id_q     <= id_q;
              rsp_status_q <= ST_BAD_RND;
              rsp_blocks_q <= k_q;
            end else begin
              k_q <= k_inc;
              if (last_blk) begin
                rsp_id_q     <= id_q;
                rsp_status_q <= ST_OK;
                rsp_blocks_q <= nblk_q;
              end else begin
                // The row for the next block is ready before its start pulse.
                row_q <= next_row;
              end
            end
          end else if (wd_expired) begin
            rsp_id_q     <= id_q;
            rsp_status_q <= ST_TIMEOUT;
            rsp_blocks_q <= k_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_pnm_job_scheduler.sv
// Directed testbench for aes_pnm_job_scheduler with a behavioural controller stub.

module tb_aes_pnm_job_scheduler;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_enc_dec;
  logic [3:0] cmd_base_row;
  logic [7:0] cmd_nblocks;
  logic [3:0] cmd_id;
  logic       ctl_start;
  logic       ctl_enc_dec;
  logic [3:0] ctl_base_row;
  logic       ctl_done;
  logic [3:0] ctl_round;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_id;
  logic [1:0] rsp_status;
  logic [7:0] rsp_blocks;
  logic       busy;
  logic [2:0] fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  int stub_delay = 40;
  int stub_bad   = -1;
  int stub_blk   = 0;
  int stub_cnt   = 0;
  bit stub_never = 0;

  logic [3:0] st_row [$];
  logic       st_enc [$];
  longint     st_time [$];
  longint     rsp_rise = 0;
  logic       rsp_prev = 0;

  aes_pnm_job_scheduler #(
    .FIFO_DEPTH(4), .ROW_W(4), .CNT_W(8), .N_ROUNDS(10), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_enc_dec(cmd_enc_dec),
    .cmd_base_row(cmd_base_row), .cmd_nblocks(cmd_nblocks), .cmd_id(cmd_id),
    .ctl_start(ctl_start), .ctl_enc_dec(ctl_enc_dec), .ctl_base_row(ctl_base_row),
    .ctl_done(ctl_done), .ctl_round(ctl_round),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_status(rsp_status), .rsp_blocks(rsp_blocks),
    .busy(busy), .fifo_level(fifo_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  // Controller stub: done pulse stub_delay cycles after each start.
  initial begin
    ctl_done  = 1'b0;
    ctl_round = 4'd0;
    forever begin
      @(posedge clk);
      #1;
      ctl_done = 1'b0;
      if (rst) begin
        stub_cnt = 0;
      end else if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          ctl_done  = 1'b1;
          ctl_round = (stub_blk == stub_bad) ? 4'd9 : 4'd10;
          stub_blk++;
        end
      end
      if (!rst && ctl_start && !stub_never) stub_cnt = stub_delay;
    end
  end

  // Monitor: log start pulses and the rising edge of rsp_valid.
  always @(negedge clk) begin
    if (ctl_start) begin
      st_row.push_back(ctl_base_row);
      st_enc.push_back(ctl_enc_dec);
      st_time.push_back($time);
    end
    if (rsp_valid && !rsp_prev) rsp_rise = $time;
    rsp_prev = rsp_valid;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    st_row.delete();
    st_enc.delete();
    st_time.delete();
  endtask

  task automatic push_cmd(input logic enc, input logic [3:0] base, input logic [7:0] nb,
                          input logic [3:0] id, output bit ok, output longint acc);
    ok  = 0;
    acc = 0;
    cmd_valid    = 1'b1;
    cmd_enc_dec  = enc;
    cmd_base_row = base;
    cmd_nblocks  = nb;
    cmd_id       = id;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        tick();
        acc = $time - 1;
        ok  = 1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_rsp(input int maxc, output bit got, output logic [3:0] id,
                          output logic [1:0] st, output logic [7:0] bl);
    got = 0; id = 0; st = 0; bl = 0;
    for (int i = 0; i < maxc; i++) begin
      if (rsp_valid) begin
        got = 1; id = rsp_id; st = rsp_status; bl = rsp_blocks;
        break;
      end
      tick();
    end
  endtask

  task automatic accept_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (ctl_start !== 1'b0) begin n_fail++; $display("FAIL reset_ctl_start: got %b want 0", ctl_start); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    n_checks++; if ({ctl_enc_dec, ctl_base_row, rsp_id, rsp_status, rsp_blocks} !== 19'd0) begin
      n_fail++; $display("FAIL reset_regs: got %h want 0", {ctl_enc_dec, ctl_base_row, rsp_id, rsp_status, rsp_blocks});
    end
    rst = 1'b0;
    tick();
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_single();
    bit ok, got; longint acc; logic [3:0] id; logic [1:0] st; logic [7:0] bl;
    stub_delay = 40; stub_bad = -1; stub_blk = 0; stub_never = 0;
    clear_log();
    push_cmd(1'b1, 4'd0, 8'd3, 4'd5, ok, acc);
    cmd_valid = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_push: accepted %0d want 1", ok); end
    n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL single_level: got %0d want 1", fifo_level); end
    wait_rsp(400, got, id, st, bl);
    n_checks++; if (!got) begin n_fail++; $display("FAIL single_rsp_seen: got %0d want 1", got); end
    n_checks++; if ({id, st, bl} !== {4'd5, 2'b00, 8'd3}) begin
      n_fail++; $display("FAIL single_rsp: got id %0d st %0d bl %0d want id 5 st 0 bl 3", id, st, bl);
    end
    n_checks++; if (st_row.size() != 3) begin
      n_fail++; $display("FAIL single_nstarts: got %0d want 3", st_row.size());
    end else begin
      n_checks++; if ({st_row[0], st_row[1], st_row[2]} !== {4'd0, 4'd4, 4'd8}) begin
        n_fail++; $display("FAIL single_rows: got %0d %0d %0d want 0 4 8", st_row[0], st_row[1], st_row[2]);
      end
      n_checks++; if ({st_enc[0], st_enc[1], st_enc[2]} !== 3'b111) begin
        n_fail++; $display("FAIL single_enc: got %b%b%b want 111", st_enc[0], st_enc[1], st_enc[2]);
      end
      n_checks++; if (st_time[0] - acc != 10) begin
        n_fail++; $display("FAIL single_start_latency: got %0d want 10", st_time[0] - acc);
      end
      n_checks++; if (st_time[1] - st_time[0] != 410) begin
        n_fail++; $display("FAIL single_restart_gap: got %0d want 410", st_time[1] - st_time[0]);
      end
      n_checks++; if (rsp_rise - st_time[2] != 410) begin
        n_fail++; $display("FAIL single_rsp_latency: got %0d want 410", rsp_rise - st_time[2]);
      end
    end
    tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 4'd5) begin
      n_fail++; $display("FAIL single_rsp_hold: got valid %b id %0d want 1 5", rsp_valid, rsp_id);
    end
    accept_rsp();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy %b want 0", busy); end
  endtask

  task automatic test_wrap();
    bit ok, got; longint acc; logic [3:0] id; logic [1:0] st; logic [7:0] bl;
    stub_delay = 5; stub_bad = -1; stub_blk = 0;
    clear_log();
    push_cmd(1'b0, 4'd12, 8'd2, 4'd7, ok, acc);
    cmd_valid = 1'b0;
    wait_rsp(100, got, id, st, bl);
    n_checks++; if (!ok || !got || {id, st, bl} !== {4'd7, 2'b00, 8'd2}) begin
      n_fail++; $display("FAIL wrap_rsp: ok %0d got %0d id %0d st %0d bl %0d want 1 1 7 0 2", ok, got, id, st, bl);
    end
    n_checks++; if (st_row.size() != 2) begin
      n_fail++; $display("FAIL wrap_nstarts: got %0d want 2", st_row.size());
    end else begin
      n_checks++; if ({st_row[0], st_row[1], st_enc[0], st_enc[1]} !== {4'd12, 4'd0, 2'b00}) begin
        n_fail++; $display("FAIL wrap_rows: got %0d %0d enc %b%b want 12 0 enc 00", st_row[0], st_row[1], st_enc[0], st_enc[1]);
      end
    end
    accept_rsp();
  endtask

  task automatic test_bad_round();
    bit ok, got; longint acc; logic [3:0] id; logic [1:0] st; logic [7:0] bl;
    stub_delay = 5; stub_bad = 1; stub_blk = 0;
    clear_log();
    push_cmd(1'b1, 4'd3, 8'd4, 4'd2, ok, acc);
    cmd_valid = 1'b0;
    wait_rsp(100, got, id, st, bl);
    n_checks++; if (!ok || !got || {id, st, bl} !== {4'd2, 2'b10, 8'd1}) begin
      n_fail++; $display("FAIL bad_round_rsp: ok %0d got %0d id %0d st %0d bl %0d want 1 1 2 2 1", ok, got, id, st, bl);
    end
    accept_rsp();
    for (int i = 0; i < 20; i++) tick();
    n_checks++; if (st_row.size() != 2) begin
      n_fail++; $display("FAIL bad_round_nstarts: got %0d want 2", st_row.size());
    end else begin
      n_checks++; if ({st_row[0], st_row[1]} !== {4'd3, 4'd7}) begin
        n_fail++; $display("FAIL bad_round_rows: got %0d %0d want 3 7", st_row[0], st_row[1]);
      end
      n_checks++; if (rsp_rise - st_time[1] != 60) begin
        n_fail++; $display("FAIL bad_round_latency: got %0d want 60", rsp_rise - st_time[1]);
      end
    end
    stub_bad = -1;
  endtask

  task automatic test_timeout();
    bit ok, got; longint acc; logic [3:0] id; logic [1:0] st; logic [7:0] bl;
    stub_never = 1;
    clear_log();
    push_cmd(1'b1, 4'd0, 8'd2, 4'd3, ok, acc);
    cmd_valid = 1'b0;
    wait_rsp(200, got, id, st, bl);
    n_checks++; if (!ok || !got || {id, st, bl} !== {4'd3, 2'b01, 8'd0}) begin
      n_fail++; $display("FAIL timeout_rsp: ok %0d got %0d id %0d st %0d bl %0d want 1 1 3 1 0", ok, got, id, st, bl);
    end
    n_checks++; if (st_row.size() != 1) begin
      n_fail++; $display("FAIL timeout_nstarts: got %0d want 1", st_row.size());
    end else begin
      n_checks++; if (rsp_rise - st_time[0] != 650) begin
        n_fail++; $display("FAIL timeout_latency: got %0d want 650", rsp_rise - st_time[0]);
      end
    end
    accept_rsp();
    stub_never = 0;
  endtask

  task automatic test_back_to_back();
    bit ok; longint acc; int nr;
    logic [3:0] c_id [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    logic [3:0] c_bs [5] = '{4'd0, 4'd1, 4'd2, 4'd9, 4'd4};
    logic [7:0] c_nb [5] = '{8'd1, 8'd0, 8'd2, 8'd1, 8'd0};
    logic [1:0] e_st [5] = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b11};
    logic [3:0] e_row [4] = '{4'd0, 4'd2, 4'd6, 4'd9};
    logic [3:0] g_id [5];
    logic [1:0] g_st [5];
    logic [7:0] g_bl [5];
    stub_delay = 3; stub_bad = -1; stub_blk = 0;
    rsp_ready = 1'b0;
    clear_log();
    for (int j = 0; j < 5; j++) begin
      push_cmd(1'b1, c_bs[j], c_nb[j], c_id[j], ok, acc);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_push%0d: accepted %0d want 1", j, ok); end
    end
    cmd_valid = 1'b0;
    n_checks++; if (fifo_level !== 3'd4 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_full: level %0d ready %b want 4 0", fifo_level, cmd_ready);
    end
    for (int i = 0; i < 20; i++) tick();
    n_checks++; if ({rsp_valid, rsp_id, rsp_status, fifo_level, cmd_ready} !== {1'b1, 4'd1, 2'b00, 3'd4, 1'b0}) begin
      n_fail++; $display("FAIL b2b_blocked: valid %b id %0d st %0d level %0d ready %b want 1 1 0 4 0",
                         rsp_valid, rsp_id, rsp_status, fifo_level, cmd_ready);
    end
    rsp_ready = 1'b1;
    nr = 0;
    for (int i = 0; i < 300 && nr < 5; i++) begin
      if (rsp_valid) begin
        g_id[nr] = rsp_id; g_st[nr] = rsp_status; g_bl[nr] = rsp_blocks;
        nr++;
      end
      tick();
    end
    rsp_ready = 1'b0;
    n_checks++; if (nr != 5) begin
      n_fail++; $display("FAIL b2b_nrsp: got %0d want 5", nr);
    end else begin
      for (int j = 0; j < 5; j++) begin
        n_checks++; if ({g_id[j], g_st[j], g_bl[j]} !== {c_id[j], e_st[j], c_nb[j]}) begin
          n_fail++; $display("FAIL b2b_rsp%0d: got id %0d st %0d bl %0d want id %0d st %0d bl %0d",
                             j, g_id[j], g_st[j], g_bl[j], c_id[j], e_st[j], c_nb[j]);
        end
      end
    end
    n_checks++; if (st_row.size() != 4) begin
      n_fail++; $display("FAIL b2b_nstarts: got %0d want 4", st_row.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        n_checks++; if (st_row[j] !== e_row[j]) begin
          n_fail++; $display("FAIL b2b_row%0d: got %0d want %0d", j, st_row[j], e_row[j]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_job();
    bit ok, got; longint acc; logic [3:0] id; logic [1:0] st; logic [7:0] bl; int nv;
    stub_delay = 40; stub_bad = -1; stub_blk = 0;
    clear_log();
    push_cmd(1'b1, 4'd0, 8'd2, 4'd8, ok, acc);
    push_cmd(1'b0, 4'd4, 8'd1, 4'd9, ok, acc);
    cmd_valid = 1'b0;
    for (int i = 0; i < 50 && st_row.size() == 0; i++) tick();
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if (busy !== 1'b1 || fifo_level !== 3'd1) begin
      n_fail++; $display("FAIL rstmid_pre: busy %b level %0d want 1 1", busy, fifo_level);
    end
    rst = 1'b1;
    tick();
    n_checks++; if ({rsp_valid, ctl_start, busy, fifo_level, cmd_ready} !== 7'd0) begin
      n_fail++; $display("FAIL rstmid_during: valid %b start %b busy %b level %0d ready %b want all 0",
                         rsp_valid, ctl_start, busy, fifo_level, cmd_ready);
    end
    rst = 1'b0;
    clear_log();
    nv = 0;
    for (int i = 0; i < 60; i++) begin
      if (rsp_valid) nv++;
      tick();
    end
    n_checks++; if (nv != 0 || st_row.size() != 0 || fifo_level !== 3'd0) begin
      n_fail++; $display("FAIL rstmid_quiet: rsp cycles %0d starts %0d level %0d want 0 0 0", nv, st_row.size(), fifo_level);
    end
    stub_delay = 5;
    push_cmd(1'b1, 4'd5, 8'd1, 4'd10, ok, acc);
    cmd_valid = 1'b0;
    wait_rsp(100, got, id, st, bl);
    n_checks++; if (!ok || !got || {id, st, bl} !== {4'd10, 2'b00, 8'd1}) begin
      n_fail++; $display("FAIL rstmid_after: ok %0d got %0d id %0d st %0d bl %0d want 1 1 10 0 1", ok, got, id, st, bl);
    end
    n_checks++; if (st_row.size() != 1 || st_row[0] !== 4'd5) begin
      n_fail++; $display("FAIL rstmid_after_row: starts %0d want 1 at row 5", st_row.size());
    end
    accept_rsp();
  endtask

  initial begin
    rst          = 1'b1;
    cmd_valid    = 1'b0;
    cmd_enc_dec  = 1'b0;
    cmd_base_row = 4'd0;
    cmd_nblocks  = 8'd0;
    cmd_id       = 4'd0;
    rsp_ready    = 1'b0;
    test_reset();
    test_single();
    test_wrap();
    test_bad_round();
    test_timeout();
    test_back_to_back();
    test_reset_mid_job();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
